// File: rtl/cmul_sched.sv
// cmul_sched: round-robin scheduler in front of one shared iterative complex
// multiplier. Requesters hand over operand pairs on valid/ready, one job at a
// time is launched with a single-cycle mul_en strobe, the product is captured
// LAT cycles later and returned on a valid/ready response channel tagged with
// the originating requester index.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester handshake (ready is one-hot or zero)
//   req_{a,b}_{r,i}          packed operands, requester k at [k*W +: W]
//   mul_en                   start strobe to the shared multiplier
//   mul_{a,b}_{r,i}          registered operands, stable while busy
//   mul_o_{r,i}              multiplier result (2W+1 bits, signed)
//   rsp_valid/rsp_ready      response handshake
//   rsp_id, rsp_r, rsp_i     requester index and product of the response
//   busy                     high while a job is in the multiplier
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrating; may grant when the response slot can take a result
// BUSY  | job in flight, counting LAT cycles until the product is final
module cmul_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*W-1:0]      req_a_r,
  input  logic [NREQ*W-1:0]      req_a_i,
  input  logic [NREQ*W-1:0]      req_b_r,
  input  logic [NREQ*W-1:0]      req_b_i,
  output logic                   mul_en,
  output logic signed [W-1:0]    mul_a_r,
  output logic signed [W-1:0]    mul_a_i,
  output logic signed [W-1:0]    mul_b_r,
  output logic signed [W-1:0]    mul_b_i,
  input  logic signed [2*W:0]    mul_o_r,
  input  logic signed [2*W:0]    mul_o_i,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic signed [2*W:0]    rsp_r,
  output logic signed [2*W:0]    rsp_i,
  output logic                   busy
);

  localparam int CNTW = $clog2(LAT + 1);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  gid_q;
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  ptr_nxt;
  logic [CNTW-1:0] cnt_q;
  logic            found;
  logic            can_acc;
  logic            accept;
  logic            capture;

  // A new job may only start if its result will have somewhere to go.
  assign can_acc = !rsp_valid || rsp_ready;
  assign capture = (state_q == BUSY) && (cnt_q == CNTW'(LAT));
  assign busy    = (state_q == BUSY);

  // Round-robin search starting at ptr_q.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr_q) + off) % NREQ;
      if (!found && req_valid[IDW'(idx)]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  assign ptr_nxt = (int'(gnt) == NREQ - 1) ? '0 : gnt + IDW'(1);

  // Gated by rst so ready reads as zero throughout reset.
  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == IDLE) && can_acc && found)
      req_ready[gnt] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = BUSY;
      BUSY:    if (capture) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      mul_en  <= 1'b0;
      mul_a_r <= '0;
      mul_a_i <= '0;
      mul_b_r <= '0;
      mul_b_i <= '0;
    end else begin
      mul_en <= accept;
      if (accept) begin
        mul_a_r <= req_a_r[int'(gnt)*W +: W];
        mul_a_i <= req_a_i[int'(gnt)*W +: W];
        mul_b_r <= req_b_r[int'(gnt)*W +: W];
        mul_b_i <= req_b_i[int'(gnt)*W +: W];
        gid_q   <= gnt;
        ptr_q   <= ptr_nxt;
        cnt_q   <= '0;
      end else if ((state_q == BUSY) && !capture) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  // A capture on the same edge as a consume wins; no capture can occur while
  // an unconsumed response is pending because grant requires can_acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_r     <= '0;
      rsp_i     <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gid_q;
      rsp_r     <= mul_o_r;
      rsp_i     <= mul_o_i;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmul_sched.sv
// Directed bench for cmul_sched with a behavioural LAT-cycle multiplier that
// drives a junk value until its result is final.
module tb_cmul_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a_r = '0, req_a_i = '0, req_b_r = '0, req_b_i = '0;
  logic                mul_en;
  logic signed [W-1:0] mul_a_r, mul_a_i, mul_b_r, mul_b_i;
  logic signed [2*W:0] mul_o_r, mul_o_i;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IDW-1:0]      rsp_id;
  logic signed [2*W:0] rsp_r, rsp_i;
  logic                busy;

  cmul_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_r(req_a_r), .req_a_i(req_a_i), .req_b_r(req_b_r), .req_b_i(req_b_i),
    .mul_en(mul_en),
    .mul_a_r(mul_a_r), .mul_a_i(mul_a_i), .mul_b_r(mul_b_r), .mul_b_i(mul_b_i),
    .mul_o_r(mul_o_r), .mul_o_i(mul_o_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_i(rsp_i), .busy(busy)
  );

  // behavioural multiplier
  logic signed [2*W:0] m_pr, m_pi;
  int   m_cnt;
  logic m_vld;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pr <= '0; m_pi <= '0; m_cnt <= 0; m_vld <= 1'b0;
    end else if (mul_en) begin
      m_pr  <= 17'(int'(mul_a_r) * int'(mul_b_r) - int'(mul_a_i) * int'(mul_b_i));
      m_pi  <= 17'(int'(mul_a_r) * int'(mul_b_i) + int'(mul_a_i) * int'(mul_b_r));
      m_cnt <= LAT - 1;
      m_vld <= 1'b1;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign mul_o_r = (m_vld && m_cnt == 0) ? m_pr : 17'h0AAAA;
  assign mul_o_i = (m_vld && m_cnt == 0) ? m_pi : 17'h05555;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input int ar, input int ai, input int br, input int bi);
    req_a_r[k*W +: W] = 8'(ar);
    req_a_i[k*W +: W] = 8'(ai);
    req_b_r[k*W +: W] = 8'(br);
    req_b_i[k*W +: W] = 8'(bi);
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!rsp_valid) check_val({tag, "_timeout"}, 0, 1);
  endtask

  // One isolated job: grant check, launch check, latency and result check.
  task automatic do_req(input string tag, input logic [3:0] mask, input int k,
                        input int ar, input int ai, input int br, input int bi,
                        input int er, input int ei);
    int lat, en_cnt;
    set_op(k, ar, ai, br, bi);
    req_valid = mask;
    #1;
    check_val({tag, "_ready"}, int'(req_ready), 1 << k);
    tick();
    req_valid = '0;
    check_val({tag, "_mul_en"}, int'(mul_en), 1);
    check_val({tag, "_busy"}, int'(busy), 1);
    check_val({tag, "_mul_a_r"}, int'(mul_a_r), ar);
    check_val({tag, "_mul_b_i"}, int'(mul_b_i), bi);
    lat = 1;
    en_cnt = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
      if (mul_en) en_cnt++;
    end
    check_val({tag, "_latency"}, lat, LAT + 2);
    check_val({tag, "_en_pulses"}, en_cnt, 1);
    check_val({tag, "_id"}, int'(rsp_id), k);
    check_val({tag, "_rsp_r"}, int'(rsp_r), er);
    check_val({tag, "_rsp_i"}, int'(rsp_i), ei);
    check_val({tag, "_busy_done"}, int'(busy), 0);
    rsp_ready = 1'b1;
    tick();
    check_val({tag, "_consumed"}, int'(rsp_valid), 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int q[$];
    int n_g, cyc, last_cyc, g, id, saw;
    logic [3:0] acc;

    // reset values, with all requests pending
    req_valid = 4'hF;
    #2;
    check_val("rst_req_ready", int'(req_ready), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_mul_en", int'(mul_en), 0);
    check_val("rst_mul_a_r", int'(mul_a_r), 0);
    check_val("rst_rsp_valid", int'(rsp_valid), 0);
    check_val("rst_rsp_r", int'(rsp_r), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // fairness: requester k computes (x - xj)(2 + 3j) = 5x + xj, x = k+1
    for (int k = 0; k < NREQ; k++) set_op(k, k + 1, -(k + 1), 2, 3);
    rsp_ready = 1'b1;
    #1;
    n_g = 0; cyc = 0; last_cyc = 0;
    while (n_g < 6 && cyc < 100) begin
      acc = req_valid & req_ready;
      if (rsp_valid && rsp_ready) begin
        id = (q.size() > 0) ? q.pop_front() : -1;
        check_val("fair_rsp_id", int'(rsp_id), id);
        check_val("fair_rsp_r", int'(rsp_r), 5 * (id + 1));
      end
      if (acc != 0) begin
        g = -1;
        for (int b = 0; b < NREQ; b++) if (acc[b]) g = b;
        check_val("fair_order", g, n_g % NREQ);
        if (n_g > 0) check_val("fair_spacing", cyc - last_cyc, LAT + 2);
        last_cyc = cyc;
        q.push_back(g);
        n_g++;
      end
      if (n_g < 6) begin
        tick();
        cyc++;
      end
    end
    check_val("fair_grants", n_g, 6);
    tick();
    req_valid = '0;
    wait_rsp("fair_last");
    id = (q.size() > 0) ? q.pop_front() : -1;
    check_val("fair_last_id", int'(rsp_id), id);
    tick();
    check_val("fair_drained", int'(rsp_valid), 0);
    rsp_ready = 1'b0;

    // backpressure: ptr is now 2, requesters 1 and 2 pending
    req_valid = 4'b0110;
    #1;
    check_val("bp_first_grant", int'(req_ready), 4'b0100);
    tick();
    wait_rsp("bp_first");
    check_val("bp_id", int'(rsp_id), 2);
    check_val("bp_rsp_r", int'(rsp_r), 15);
    check_val("bp_rsp_i", int'(rsp_i), 3);
    for (int c = 0; c < 20; c++) begin
      tick();
      check_val("bp_hold_valid", int'(rsp_valid), 1);
      check_val("bp_hold_id", int'(rsp_id), 2);
      check_val("bp_hold_r", int'(rsp_r), 15);
      check_val("bp_no_ready", int'(req_ready), 0);
      check_val("bp_not_busy", int'(busy), 0);
    end
    rsp_ready = 1'b1;
    #1;
    check_val("bp_same_cycle_grant", int'(req_ready), 4'b0010);
    tick();
    req_valid = '0;
    check_val("bp_consumed", int'(rsp_valid), 0);
    check_val("bp_busy", int'(busy), 1);
    check_val("bp_mul_a_r", int'(mul_a_r), 2);
    wait_rsp("bp_second");
    check_val("bp2_id", int'(rsp_id), 1);
    check_val("bp2_rsp_r", int'(rsp_r), 10);
    check_val("bp2_rsp_i", int'(rsp_i), 2);
    tick();
    check_val("bp2_consumed", int'(rsp_valid), 0);
    rsp_ready = 1'b0;

    // single request: (3+4j)(5-2j) = 23+14j
    do_req("single", 4'b0100, 2, 3, 4, 5, -2, 23, 14);
    // width extremes
    do_req("ext_min", 4'b0001, 0, -128, -128, -128, -128, 0, 32768);
    do_req("ext_mix", 4'b0010, 1, 127, -128, 127, 127, 32385, -127);

    // sparse: only 3, then ptr must be 0; a request dropped before its edge is not served
    do_req("sparse3", 4'b1000, 3, 2, 0, 7, 0, 14, 0);
    req_valid = 4'b1011;
    #1;
    check_val("sparse_ptr0", int'(req_ready), 4'b0001);
    do_req("sparse1", 4'b0010, 1, 0, 3, 0, 5, -15, 0);

    // reset in the third busy cycle
    set_op(3, 9, 9, 9, 9);
    req_valid = 4'b1000;
    #1;
    check_val("mid_rst_grant", int'(req_ready), 4'b1000);
    tick();
    req_valid = '0;
    tick();
    tick();
    check_val("mid_rst_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_busy", int'(busy), 0);
    check_val("mid_rst_mul_en", int'(mul_en), 0);
    check_val("mid_rst_mul_a_r", int'(mul_a_r), 0);
    check_val("mid_rst_mul_b_i", int'(mul_b_i), 0);
    check_val("mid_rst_rsp_valid", int'(rsp_valid), 0);
    check_val("mid_rst_rsp_id", int'(rsp_id), 0);
    tick();
    rst = 1'b0;
    saw = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid || busy) saw = 1;
    end
    check_val("mid_rst_no_rsp", saw, 0);
    // (1+2j)(3+4j) = -5+10j, requester 0 wins over 3 since ptr restarted at 0
    do_req("post_rst", 4'b1001, 0, 1, 2, 3, 4, -5, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1);
  end

endmodule

// File: doc/cmul_sched.md
# cmul_sched

Round-robin scheduler that shares one iterative complex multiplier (operands `W`-bit signed, 4-cycle latency, single `i_en` start strobe) among `NREQ` requesters. It accepts operand pairs over valid/ready handshakes and presents each pair to the multiplier with a one-cycle start pulse. It then waits the fixed latency, captures the product into a response buffer tagged with the requester index, and returns it over a valid/ready response channel. The block sits between the filter/FFT front-end clients and the shared multiplier instance.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `W`, default 8: operand width, signed.
- `LAT`, default 4: cycles from the `mul_en` cycle to a final product at `mul_o_*`, ≥1.
- `IDW`, default `$clog2(NREQ)`: requester-id width, derived.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req_valid`, in, `NREQ`: per-requester operand valid.
- `req_ready`, out, `NREQ`: per-requester accept; combinational, one-hot or zero.
- `req_a_r`, `req_a_i`, `req_b_r`, `req_b_i`, in, `NREQ*W` each: packed operands; requester k uses bits `[k*W +: W]`.
- `mul_en`, out, 1: start strobe to the multiplier.
- `mul_a_r`, `mul_a_i`, `mul_b_r`, `mul_b_i`, out, `W` each: registered operands to the multiplier.
- `mul_o_r`, `mul_o_i`, in, `2W+1` each: multiplier results, signed.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response accept.
- `rsp_id`, out, `IDW`: index of the requester the response belongs to.
- `rsp_r`, `rsp_i`, out, `2W+1` each: product, signed.
- `busy`, out, 1: high while the state is BUSY.

## Operation
- States: IDLE and BUSY. Internal registers: `ptr` (`IDW`, round-robin pointer), `cnt` (0..`LAT`), `gid` (`IDW`).
- Grant in IDLE: `can_acc = !rsp_valid || rsp_ready`. If `can_acc` and any `req_valid` is high, `g` is the first k with `req_valid[k]`, searching k = `ptr`, `ptr`+1, … mod `NREQ`.
  - `req_ready[g]` = 1; all other bits 0.
  - In BUSY, or when `can_acc` = 0, `req_ready` = 0.
- Accept edge (`req_valid[g]` & `req_ready[g]`):
  - Latch requester g's four operands into `mul_*`.
  - Set `gid` ← g, `ptr` ← (g+1) mod `NREQ`, `mul_en` ← 1, `cnt` ← 0, state ← BUSY.
- In BUSY:
  - `mul_en` is high only in the first BUSY cycle.
  - `mul_a_*`/`mul_b_*` stay stable for the whole BUSY period.
  - `cnt` increments each cycle.
- Capture, on the edge at `cnt == LAT`:
  - `rsp_r` ← `mul_o_r`, `rsp_i` ← `mul_o_i`, `rsp_id` ← `gid`, `rsp_valid` ← 1, state ← IDLE.
- Response channel:
  - `rsp_valid` clears on an edge with `rsp_ready` = 1 unless a new capture occurs on the same edge; the capture wins.
  - While `rsp_valid` && !`rsp_ready`, `rsp_r`, `rsp_i` and `rsp_id` hold stable.
- Arithmetic: no rounding or saturation; the block passes the `2W+1`-bit product unchanged.
- Requester operands need only be stable in the accept cycle.
- Reset values: state IDLE, `ptr` 0, `cnt` 0, `gid` 0, `mul_en` 0, all `mul_*` operands 0, `rsp_valid` 0, `rsp_id` 0, `rsp_r` and `rsp_i` 0, `busy` 0, `req_ready` 0.
- Reset mid-operation discards the in-flight job with no response. The multiplier shares the same `rst`.
- A request that drops `req_valid` before being granted is simply not served; no state changes.

## Timing
- Accept in cycle t. `mul_en` = 1 in cycle t+1. Capture on the edge ending cycle t+1+`LAT`. `rsp_valid` = 1 from cycle t+2+`LAT`.
- Request-to-response latency is `LAT`+2 cycles (6 at default).
- The next accept can occur no earlier than the first IDLE cycle, t+2+`LAT`, provided `can_acc` holds.
- Maximum throughput is one operation per `LAT`+2 cycles.
- `busy` = 1 exactly for cycles t+1 .. t+1+`LAT`.

## Test plan
The bench uses either the shared multiplier instance or a behavioural `LAT`-cycle model.
- Single request: requester 2 sends (3+4j)×(5−2j) → `req_ready[2]` is high one cycle, `mul_en` pulses once; after 6 cycles `rsp_id` = 2, `rsp_r` = 23, `rsp_i` = 14.
- Width extreme: (−128−128j)×(−128−128j) → `rsp_r` = 0, `rsp_i` = 32768 in 17 bits; (127−128j)×(127+127j) → `rsp_r` = 32385, `rsp_i` = −127.
- Fairness: all four `req_valid` held high with `rsp_ready` = 1 → grant order 0,1,2,3,0,1; each accept is spaced 6 cycles apart.
- Backpressure: `rsp_ready` = 0 for 20 cycles after the first response → response fields hold, no `req_ready` asserts, `busy` = 0. When `rsp_ready` rises, the response is consumed and the next grant occurs in the same cycle.
- Reset mid-operation: assert `rst` during cycle 3 of BUSY → all outputs return to reset values immediately, and no response is produced. After release, a new request from requester 0 completes normally and is granted first (`ptr` = 0).
- Sparse requests: only requester 3 valid, then only requester 1 → both served. After the grant to 3, `ptr` = 0.
